add_f32_arbiter: RTL

- Round-robin arbiter that shares one combinational add_f32 instance between NREQ requesters inside a PE.
- Each requester has its own valid/ready request port.
- Results return on one registered response channel, tagged with the requester index. The channel supports backpressure.
- Sustains one addition per cycle when the response side is not stalled.

---
 rtl/add_f32_arbiter_pkg.sv | 18 +
 rtl/add_f32.sv | 95 +++++++++
 rtl/add_f32_arbiter_rr_arbiter.sv | 45 ++++
 rtl/add_f32_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/add_f32_arbiter_pkg.sv
// Shared definitions for the add_f32 arbiter slice: FP32 constants and response FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package add_f32_arbiter_pkg;

    localparam int          FP32_WIDTH = 32;
    localparam logic [31:0] FP32_ZERO  = 32'h0000_0000;
    localparam logic [31:0] FP32_PINF  = 32'h7f80_0000;
    localparam logic [31:0] FP32_NINF  = 32'hff80_0000;
    localparam logic [31:0] FP32_QNAN  = 32'h7fc0_0000;

    // Response register occupancy; the encoding doubles as rsp_valid.
    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/add_f32.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even, subnormals supported.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
// Ports: a, b (operands), sum (result). Any NaN input yields the canonical quiet NaN.
module add_f32
    import add_f32_arbiter_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    logic        a_nan, b_nan, a_inf, b_inf;
    logic        swap, sl, eff_sub, round_up;
    logic [7:0]  ea, eb, el, es, el_eff, es_eff, d;
    logic [4:0]  dd, lz;
    logic [23:0] ma, mb, ml, ms;
    logic [49:0] ms_sh;
    logic [26:0] ml_x, ms_x, n;
    logic [27:0] s;
    logic [9:0]  e, sh, e_f;
    logic [24:0] m_r;
    logic [22:0] mant;

    always_comb begin
        ea      = a[30:23];
        eb      = b[30:23];
        ma      = {|ea, a[22:0]};
        mb      = {|eb, b[22:0]};
        a_nan   = (&ea) && (|a[22:0]);
        b_nan   = (&eb) && (|b[22:0]);
        a_inf   = (&ea) && !(|a[22:0]);
        b_inf   = (&eb) && !(|b[22:0]);
        eff_sub = a[31] ^ b[31];

        // Order operands by magnitude so the difference path never goes negative.
        swap    = b[30:0] > a[30:0];
        sl      = swap ? b[31] : a[31];
        el      = swap ? eb : ea;
        es      = swap ? ea : eb;
        ml      = swap ? mb : ma;
        ms      = swap ? ma : mb;
        el_eff  = (el == 8'd0) ? 8'd1 : el;
        es_eff  = (es == 8'd0) ? 8'd1 : es;
        d       = el_eff - es_eff;

        // Align the smaller operand; everything shifted past the round bit folds into sticky.
        dd      = (d > 8'd26) ? 5'd26 : d[4:0];
        ms_sh   = {ms, 26'b0} >> dd;
        ms_x    = {ms_sh[49:24], |ms_sh[23:0]};
        ml_x    = {ml, 3'b000};
        s       = eff_sub ? ({1'b0, ml_x} - {1'b0, ms_x}) : ({1'b0, ml_x} + {1'b0, ms_x});

        lz = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (s[i]) lz = 5'(26 - i);
        end

        // Normalise; left shift is clamped so the exponent bottoms out at the subnormal level.
        e  = {2'b00, el_eff};
        sh = 10'd0;
        if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            sh = ({5'b0, lz} < (e - 10'd1)) ? {5'b0, lz} : (e - 10'd1);
            n  = s[26:0] << sh;
            e  = e - sh;
        end

        round_up = n[2] & (n[1] | n[0] | n[3]);
        m_r      = {1'b0, n[26:3]} + {24'b0, round_up};
        if (m_r[24]) begin
            e_f  = e + 10'd1;
            mant = m_r[23:1];
        end else begin
            e_f  = m_r[23] ? e : 10'd0;
            mant = m_r[22:0];
        end

        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            sum = FP32_QNAN;
        end else if (a_inf || b_inf) begin
            sum = (a_inf ? a[31] : b[31]) ? FP32_NINF : FP32_PINF;
        end else if (s == 28'd0) begin
            // Exact cancellation rounds to +0; like-signed zeros keep their sign.
            sum = eff_sub ? FP32_ZERO : {sl, 31'b0};
        end else if (e_f >= 10'd255) begin
            sum = sl ? FP32_NINF : FP32_PINF;
        end else begin
            sum = {sl, e_f[7:0], mant};
        end
    end

endmodule

// File: rtl/add_f32_arbiter_rr_arbiter.sv
// Round-robin grant search starting at ptr, wrapping upward modulo NREQ.
// Latency: 0 cycles (pure combinational).
// Backpressure: enable low forces gnt_onehot to zero; gnt_idx/any still reflect req.
// Ports: req, ptr, enable in; gnt_onehot, gnt_idx, any out.
module rr_arbiter #(
    parameter int NREQ     = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NREQ-1:0]     req,
    input  logic [ID_WIDTH-1:0] ptr,
    input  logic                enable,
    output logic [NREQ-1:0]     gnt_onehot,
    output logic [ID_WIDTH-1:0] gnt_idx,
    output logic                any
);

    logic                found;
    logic [ID_WIDTH:0]   idx_w;
    logic [ID_WIDTH-1:0] sel;

    always_comb begin
        found   = 1'b0;
        gnt_idx = '0;
        idx_w   = '0;
        sel     = '0;
        for (int k = 0; k < NREQ; k++) begin
            // Explicit wrap so non-power-of-two NREQ never yields an index >= NREQ.
            idx_w = {1'b0, ptr} + (ID_WIDTH + 1)'(k);
            if (idx_w >= (ID_WIDTH + 1)'(NREQ)) idx_w = idx_w - (ID_WIDTH + 1)'(NREQ);
            sel = idx_w[ID_WIDTH-1:0];
            if (!found && req[sel]) begin
                found   = 1'b1;
                gnt_idx = sel;
            end
        end
    end

    always_comb begin
        gnt_onehot = '0;
        if (enable && found) gnt_onehot[gnt_idx] = 1'b1;
    end

    assign any = |req;

endmodule

// File: rtl/add_f32_arbiter.sv
// Shares one combinational add_f32 between NREQ requesters; registered, id-tagged response.
// Latency: result on rsp_* the cycle after the accept edge; 1 op/cycle when rsp_ready is high.
// Backpressure: rsp_valid && !rsp_ready stalls everything and drops all req_ready bits.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_a/req_b per requester;
//        rsp_valid/rsp_ready/rsp_sum/rsp_id response; busy and op_count status.
module add_f32_arbiter
    import add_f32_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int ID_WIDTH  = 2,
    parameter int CNT_WIDTH = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NREQ-1:0]              req_valid,
    output logic [NREQ-1:0]              req_ready,
    input  logic [NREQ*FP32_WIDTH-1:0]   req_a,
    input  logic [NREQ*FP32_WIDTH-1:0]   req_b,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [FP32_WIDTH-1:0]        rsp_sum,
    output logic [ID_WIDTH-1:0]          rsp_id,
    output logic                         busy,
    output logic [CNT_WIDTH-1:0]         op_count
);

    rsp_state_t            state_q, state_d;
    logic [ID_WIDTH-1:0]   ptr, ptr_nxt, gnt_idx;
    logic [NREQ-1:0]       gnt_onehot;
    logic                  any_req, can_accept, accept;
    logic [FP32_WIDTH-1:0] op_a, op_b, add_sum;

    // Same-cycle drain and refill: a consumed response frees the slot immediately.
    assign can_accept = !rsp_valid || rsp_ready;

    rr_arbiter #(
        .NREQ     (NREQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_arbiter (
        .req        (req_valid),
        .ptr        (ptr),
        .enable     (can_accept && !rst),
        .gnt_onehot (gnt_onehot),
        .gnt_idx    (gnt_idx),
        .any        (any_req)
    );

    assign req_ready = gnt_onehot;
    assign accept    = |gnt_onehot;
    assign ptr_nxt   = (gnt_idx == ID_WIDTH'(NREQ - 1)) ? '0 : gnt_idx + ID_WIDTH'(1);

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == ID_WIDTH'(i)) begin
                op_a = req_a[i*FP32_WIDTH +: FP32_WIDTH];
                op_b = req_b[i*FP32_WIDTH +: FP32_WIDTH];
            end
        end
    end

    add_f32 u_add_f32 (
        .a   (op_a),
        .b   (op_b),
        .sum (add_sum)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= RSP_EMPTY;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RSP_EMPTY: if (accept) state_d = RSP_FULL;
            RSP_FULL:  if (rsp_ready && !accept) state_d = RSP_EMPTY;
            default:   state_d = RSP_EMPTY;
        endcase
    end

    assign rsp_valid = (state_q == RSP_FULL);
    assign busy      = rsp_valid || any_req;

    // Payload, pointer and counter move only on accept; a drain leaves the payload in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_sum  <= FP32_ZERO;
            rsp_id   <= '0;
            ptr      <= '0;
            op_count <= '0;
        end else if (accept) begin
            rsp_sum  <= add_sum;
            rsp_id   <= gnt_idx;
            ptr      <= ptr_nxt;
            op_count <= op_count + CNT_WIDTH'(1);
        end
    end

endmodule
